// File: rtl/aidc_lite_decomp_zrle_gen.sv
// Zero-run-length (nonzero-mask) block decompressor.
// A compressed block is a bit stream, MSB first. The first HDR_W bits of the sop word are a
// header and are dropped. The stream then holds NUM_BEATS beat codes. Each code is a
// LANES-bit nonzero mask followed by the nonzero words in descending lane order.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   valid_i/ready_o        input word handshake; sop_i/eop_i mark the first/last word of a block
//   data_i                 code word, MSB first in the stream
//   valid_o/ready_i        output beat handshake
//   addr_o, data_o         beat index and decoded beat; both are zero whenever no beat is held,
//                          so they can be ORed with sibling decompressors
//   done_o                 block fully emitted (high from reset until the next sop)
//   err_o                  sticky protocol error
module aidc_lite_decomp_zrle_gen #(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned LANES     = 4,
  parameter int unsigned NUM_BEATS = 16,
  parameter int unsigned IN_W      = 32,
  parameter int unsigned HDR_W     = 2,
  parameter int unsigned BUF_W     = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic                          sop_i,
  input  logic                          eop_i,
  input  logic [IN_W-1:0]               data_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(NUM_BEATS)-1:0]  addr_o,
  output logic [LANES*WORD_W-1:0]       data_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int unsigned AW = $clog2(NUM_BEATS);
  localparam int unsigned CW = $clog2(BUF_W + 1);
  localparam int unsigned DW = LANES * WORD_W;

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW:0]      beat_q, beat_d;   // beats decoded so far in this block
  logic             eop_seen_q, eop_seen_d;
  logic             valid_q, valid_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [LANES-1:0] mask;
  logic [CW-1:0]    blen;
  logic [DW-1:0]    beat_data;
  logic [BUF_W-1:0] word_win;
  logic [CW:0]      free_bits;
  logic             accept;
  logic             dec;
  logic [CW-1:0]    cnt_after;
  logic [BUF_W-1:0] buf_after;
  logic [CW:0]      cnt_sum;

  assign mask = buf_q[BUF_W-1 -: LANES];

  // Walk lanes from the top; each set mask bit takes the next word after the mask.
  always_comb begin
    beat_data = '0;
    word_win  = '0;
    blen      = CW'(LANES);
    for (int k = LANES - 1; k >= 0; k--) begin
      if (mask[k]) begin
        word_win = buf_q << blen;
        beat_data[k*WORD_W +: WORD_W] = word_win[BUF_W-1 -: WORD_W];
        blen = blen + CW'(WORD_W);
      end
    end
  end

  assign free_bits = (CW+1)'(BUF_W) - {1'b0, cnt_q};
  // Once the block is done the next sop must always get in, even if leftover bits fill the buffer.
  assign ready_o   = done_q | (~eop_seen_q & (free_bits >= (CW+1)'(IN_W)));
  assign accept    = valid_i & ready_o;

  assign dec = ~done_q & (beat_q != (AW+1)'(NUM_BEATS)) & (~valid_q | ready_i) &
               ((cnt_q >= blen) | eop_seen_q);

  assign cnt_after = ~dec ? cnt_q : ((cnt_q >= blen) ? cnt_q - blen : '0);
  assign buf_after = dec ? (buf_q << blen) : buf_q;
  assign cnt_sum   = {1'b0, cnt_after} + (CW+1)'(IN_W);

  always_comb begin
    buf_d      = buf_after;
    cnt_d      = cnt_after;
    beat_d     = beat_q;
    eop_seen_d = eop_seen_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = done_q;
    err_d      = err_q;

    if (dec) begin
      valid_d = 1'b1;
      addr_d  = beat_q[AW-1:0];
      data_d  = beat_data;
      beat_d  = beat_q + (AW+1)'(1);
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      addr_d  = '0;
      data_d  = '0;
    end

    if (valid_q && ready_i && (addr_q == AW'(NUM_BEATS - 1))) begin
      done_d = 1'b1;
    end

    if (accept) begin
      if (sop_i) begin
        // A sop restarts everything, dropping any beat or decode in flight.
        buf_d      = {data_i[IN_W-HDR_W-1:0], {(BUF_W-IN_W+HDR_W){1'b0}}};
        cnt_d      = CW'(IN_W - HDR_W);
        beat_d     = '0;
        done_d     = 1'b0;
        eop_seen_d = eop_i;
        valid_d    = 1'b0;
        addr_d     = '0;
        data_d     = '0;
        if (!done_q) err_d = 1'b1;
      end else begin
        // Bits past cnt are always zero, so OR-ing the new word in is enough.
        buf_d = buf_after | ({data_i, {(BUF_W-IN_W){1'b0}}} >> cnt_after);
        cnt_d = (cnt_sum > (CW+1)'(BUF_W)) ? CW'(BUF_W) : cnt_sum[CW-1:0];
        if (eop_i) eop_seen_d = 1'b1;
        if (done_q && eop_seen_q) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      cnt_q      <= '0;
      beat_q     <= '0;
      eop_seen_q <= 1'b0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      eop_seen_q <= eop_seen_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule
